shift_add_multiplier: RTL and testbench

// Sequential unsigned N x N -> N (low half) multiplier built around one

---
 rtl/shift_add_multiplier.sv | 121 ++++++++++++
 tb/tb_shift_add_multiplier.sv | 137 +++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - sequential unsigned N x N -> N shift-and-add multiplier
// One shifter forms a << cnt each BUSY cycle; early exit once no higher b bits remain.

module shift_left_logical #(
  parameter int N = 32
) (
  input  logic [N-1:0]         data_i,
  input  logic [$clog2(N)-1:0] shamt_i,
  output logic [N-1:0]         data_o
);
  assign data_o = data_i << shamt_i;
endmodule

module shift_add_multiplier #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] product,
  output logic         overflow
);
  localparam int SW = $clog2(N);
  localparam logic [SW-1:0] CNT_MAX = SW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, a_d, b_q, b_d, acc_q, acc_d, prod_q, prod_d;
  logic [SW-1:0]  cnt_q, cnt_d;
  logic           ovf_q, ovf_d, oflow_q, oflow_d;

  logic [N-1:0]   shifted;
  logic [N:0]     sum;
  logic [N-1:0]   b_rem;
  logic           lost, last;

  shift_left_logical #(.N(N)) u_shl (
    .data_i  (a_q),
    .shamt_i (cnt_q),
    .data_o  (shifted)
  );

  assign sum   = {1'b0, acc_q} + {1'b0, shifted};
  // top cnt bits of a fall off the end of the shifter
  assign lost  = |(a_q & ~({N{1'b1}} >> cnt_q));
  assign b_rem = b_q >> cnt_q;
  assign last  = ((b_rem >> 1) == '0) || (cnt_q == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      prod_q  <= '0;
      oflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      prod_q  <= prod_d;
      oflow_q <= oflow_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    prod_d  = prod_q;
    oflow_d = oflow_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          cnt_d   = '0;
          acc_d   = '0;
          ovf_d   = 1'b0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (b_q[cnt_q]) begin
          acc_d = sum[N-1:0];
          ovf_d = ovf_q | sum[N] | lost;
        end
        if (last) begin
          state_d = S_DONE;
          prod_d  = acc_d;
          oflow_d = ovf_d;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign product   = prod_q;
  assign overflow  = oflow_q;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - directed vector bench for shift_add_multiplier
module tb_shift_add_multiplier;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, overflow;
  logic [31:0] a, b, product;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] prod;
    logic        ovf;
    int          k;
  } vec_t;

  vec_t vecs [12];

  shift_add_multiplier #(.N(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // accept at one edge, then count edges until out_valid rises
  task automatic wait_result(input string name, input int k, input logic [31:0] p, input logic o);
    int edges = 0;
    while (!out_valid && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    check({name, " latency"}, edges, k);
    check({name, " product"}, product, p);
    check({name, " overflow"}, {31'b0, overflow}, {31'b0, o});
  endtask

  task automatic do_op(input string name, input logic [31:0] ia, input logic [31:0] ib,
                       input logic [31:0] p, input logic o, input int k);
    a = ia; b = ib; in_valid = 1'b1;
    check({name, " in_ready"}, {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result(name, k, p, o);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, " handoff"}, {30'b0, out_valid, in_ready}, 32'b01);
  endtask

  initial begin
    vecs[0]  = '{32'd3,        32'd5,        32'd15,       1'b0, 3};
    vecs[1]  = '{32'hDEADBEEF, 32'd0,        32'd0,        1'b0, 1};
    vecs[2]  = '{32'd0,        32'hFFFFFFFF, 32'd0,        1'b0, 32};
    vecs[3]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b1, 32};
    vecs[4]  = '{32'h80000000, 32'd2,        32'd0,        1'b1, 2};
    vecs[5]  = '{32'h00010000, 32'h0000FFFF, 32'hFFFF0000, 1'b0, 16};
    vecs[6]  = '{32'h00010000, 32'h00010000, 32'd0,        1'b1, 17};
    vecs[7]  = '{32'h12345678, 32'd1,        32'h12345678, 1'b0, 1};
    vecs[8]  = '{32'd1,        32'h80000000, 32'h80000000, 1'b0, 32};
    vecs[9]  = '{32'd2,        32'h80000000, 32'd0,        1'b1, 32};
    vecs[10] = '{32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, 1'b0, 17};
    vecs[11] = '{32'd3,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1, 32};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    #1;
    check("reset in_ready", {31'b0, in_ready}, 32'd1);
    check("reset out_valid", {31'b0, out_valid}, 32'd0);
    check("reset product", product, 32'd0);
    check("reset overflow", {31'b0, overflow}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++)
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].ovf, vecs[i].k);

    // backpressure: result held, in_valid pulses ignored, re-issue only after handoff
    a = 32'd3; b = 32'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result("bp", 3, 32'd15, 1'b0);
    for (int c = 0; c < 5; c++) begin
      in_valid = c[0]; a = 32'd9; b = 32'd9;
      @(posedge clk); #1;
      check("bp hold product", product, 32'd15);
      check("bp hold flags", {29'b0, out_valid, in_ready, overflow}, 32'b100);
    end
    a = 32'd7; b = 32'd6; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp release", {30'b0, out_valid, in_ready}, 32'b01);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp reissue accepted", {31'b0, in_ready}, 32'd0);
    wait_result("bp reissue", 3, 32'd42, 1'b0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // reset partway through a long operation
    a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midop rst flags", {30'b0, out_valid, in_ready}, 32'b01);
    check("midop rst product", product, 32'd0);
    check("midop rst overflow", {31'b0, overflow}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_op("post rst", 32'd7, 32'd6, 32'd42, 1'b0, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
